// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable baud-rate generator for the UART.
//
// Produces an oversampled RX tick with phase index, a mid-bit RX sample
// strobe, an RX end-of-bit strobe and a TX bit tick from one divisor.
// The divisor is written low byte first into a shadow register; the high-byte
// write commits the full value (clamped to MIN_DIV) and reloads both counters.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   baud_we      register write strobe (one cycle)
//   baud_wsel    0 = low byte (shadow), 1 = high byte (commit)
//   baud_wdata   write data
//   rx_en        RX timing enable
//   rx_restart   start-bit edge; realigns RX phase
//   tx_en        TX timing enable
//   div_q        active divisor (readback)
//   rx_tick      oversample tick
//   rx_phase     oversample index within the current RX bit
//   rx_sample    mid-bit sample strobe
//   rx_bit_end   end-of-bit strobe
//   tx_tick      TX bit-boundary tick
module uart_baud_gen #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned OS_LOG2     = 4,
  parameter int unsigned DEFAULT_DIV = 325,
  parameter int unsigned MIN_DIV     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_we,
  input  logic                 baud_wsel,
  input  logic [7:0]           baud_wdata,
  input  logic                 rx_en,
  input  logic                 rx_restart,
  input  logic                 tx_en,
  output logic [DIV_WIDTH-1:0] div_q,
  output logic                 rx_tick,
  output logic [OS_LOG2-1:0]   rx_phase,
  output logic                 rx_sample,
  output logic                 rx_bit_end,
  output logic                 tx_tick
);

  localparam int unsigned TxWidth = DIV_WIDTH + OS_LOG2;
  localparam int unsigned Os      = 2 ** OS_LOG2;

  localparam logic [DIV_WIDTH-1:0] DivRst    = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DivMin    = DIV_WIDTH'(MIN_DIV);
  localparam logic [7:0]           ShadowRst = 8'(DEFAULT_DIV);
  localparam logic [TxWidth-1:0]   TxRst     = {DivRst, {OS_LOG2{1'b1}}};
  localparam logic [OS_LOG2-1:0]   PhaseMid  = OS_LOG2'(Os / 2 - 1);
  localparam logic [OS_LOG2-1:0]   PhaseLast = OS_LOG2'(Os - 1);

  // (div+1)*OS-1 is just div with OS_LOG2 ones appended; cannot overflow.
  function automatic logic [TxWidth-1:0] tx_reload(input logic [DIV_WIDTH-1:0] div);
    return {div, {OS_LOG2{1'b1}}};
  endfunction

  logic [7:0]           shadow_q, shadow_d;
  logic [DIV_WIDTH-1:0] div_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [TxWidth-1:0]   tx_cnt_q, tx_cnt_d;
  logic [OS_LOG2-1:0]   rx_phase_d;
  logic                 rx_tick_d, rx_sample_d, rx_bit_end_d, tx_tick_d;
  // Previous-cycle enables: the first enabled edge (including the first edge
  // after reset release) loads the counter rather than counting.
  logic                 rx_en_q, tx_en_q;

  logic                 commit;
  logic [DIV_WIDTH-1:0] commit_raw;
  logic [DIV_WIDTH-1:0] commit_div;

  assign commit     = baud_we && baud_wsel;
  assign commit_raw = {baud_wdata[DIV_WIDTH-9:0], shadow_q};
  assign commit_div = (commit_raw < DivMin) ? DivMin : commit_raw;

  always_comb begin
    shadow_d     = shadow_q;
    div_d        = div_q;
    rx_cnt_d     = rx_cnt_q;
    tx_cnt_d     = tx_cnt_q;
    rx_phase_d   = rx_phase;
    rx_tick_d    = 1'b0;
    rx_sample_d  = 1'b0;
    rx_bit_end_d = 1'b0;
    tx_tick_d    = 1'b0;

    if (baud_we && !baud_wsel) begin
      shadow_d = baud_wdata;
    end

    if (commit) begin
      // Commit wins over restart and drops any tick due this cycle.
      div_d      = commit_div;
      rx_cnt_d   = commit_div;
      rx_phase_d = '0;
      tx_cnt_d   = tx_reload(commit_div);
    end else begin
      if (!rx_en || !rx_en_q || rx_restart) begin
        rx_cnt_d   = div_q;
        rx_phase_d = '0;
      end else if (rx_cnt_q == '0) begin
        rx_cnt_d     = div_q;
        rx_tick_d    = 1'b1;
        rx_sample_d  = (rx_phase == PhaseMid);
        rx_bit_end_d = (rx_phase == PhaseLast);
        rx_phase_d   = rx_phase + OS_LOG2'(1);
      end else begin
        rx_cnt_d = rx_cnt_q - DIV_WIDTH'(1);
      end

      if (!tx_en || !tx_en_q) begin
        tx_cnt_d = tx_reload(div_q);
      end else if (tx_cnt_q == '0) begin
        tx_cnt_d  = tx_reload(div_q);
        tx_tick_d = 1'b1;
      end else begin
        tx_cnt_d = tx_cnt_q - TxWidth'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= ShadowRst;
      div_q      <= DivRst;
      rx_cnt_q   <= DivRst;
      tx_cnt_q   <= TxRst;
      rx_phase   <= '0;
      rx_en_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      rx_tick    <= 1'b0;
      rx_sample  <= 1'b0;
      rx_bit_end <= 1'b0;
      tx_tick    <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      div_q      <= div_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_phase   <= rx_phase_d;
      rx_en_q    <= rx_en;
      tx_en_q    <= tx_en;
      rx_tick    <= rx_tick_d;
      rx_sample  <= rx_sample_d;
      rx_bit_end <= rx_bit_end_d;
      tx_tick    <= tx_tick_d;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Testbench for uart_baud_gen: directed stimulus pushes expected tick events
// (edge number, strobes, phase) into queues; a monitor pops and compares each
// time the DUT raises rx_tick or tx_tick.
module tb_uart_baud_gen;

  logic        clk;
  logic        rst_n;
  logic        baud_we;
  logic        baud_wsel;
  logic [7:0]  baud_wdata;
  logic        rx_en;
  logic        rx_restart;
  logic        tx_en;
  logic [15:0] div_q;
  logic        rx_tick;
  logic [3:0]  rx_phase;
  logic        rx_sample;
  logic        rx_bit_end;
  logic        tx_tick;

  uart_baud_gen #(
    .DIV_WIDTH  (16),
    .OS_LOG2    (4),
    .DEFAULT_DIV(325),
    .MIN_DIV    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_we   (baud_we),
    .baud_wsel (baud_wsel),
    .baud_wdata(baud_wdata),
    .rx_en     (rx_en),
    .rx_restart(rx_restart),
    .tx_en     (tx_en),
    .div_q     (div_q),
    .rx_tick   (rx_tick),
    .rx_phase  (rx_phase),
    .rx_sample (rx_sample),
    .rx_bit_end(rx_bit_end),
    .tx_tick   (tx_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge number N, cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int cyc;
    int flags;  // phase_after*4 + sample*2 + bit_end
  } rx_ev_t;

  rx_ev_t rx_q[$];
  int     tx_q[$];
  bit     rx_mon = 1'b0;
  bit     tx_mon = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic push_rx(input int first, input int period, input int n, input int ph0);
    for (int i = 0; i < n; i++) begin
      rx_ev_t ev;
      int     pre;
      pre      = (ph0 + i) % 16;
      ev.cyc   = first + i * period;
      ev.flags = ((pre + 1) % 16) * 4 + ((pre == 7) ? 2 : 0) + ((pre == 15) ? 1 : 0);
      rx_q.push_back(ev);
    end
  endtask

  task automatic push_tx(input int first, input int period, input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(first + i * period);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic end_window(input int last);
    wait_until(last + 1);
    rx_mon = 1'b0;
    tx_mon = 1'b0;
    check("rx events outstanding", rx_q.size(), 0);
    check("tx events outstanding", tx_q.size(), 0);
    rx_q.delete();
    tx_q.delete();
  endtask

  task automatic wr_lo(input logic [7:0] d);
    @(negedge clk);
    baud_we = 1'b1; baud_wsel = 1'b0; baud_wdata = d;
    @(negedge clk);
    baud_we = 1'b0;
  endtask

  // Returns the edge number at which the commit is sampled.
  task automatic commit(input logic [7:0] hi, input bit restart, input bit mon, output int e);
    @(negedge clk);
    baud_we = 1'b1; baud_wsel = 1'b1; baud_wdata = hi; rx_restart = restart;
    e = cyc + 1;
    if (mon) begin
      rx_mon = 1'b1;
      tx_mon = 1'b1;
    end
    @(negedge clk);
    baud_we = 1'b0; rx_restart = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each active edge.
  initial begin
    rx_ev_t ev;
    int     t;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (rx_mon) begin
          if (!rx_tick && (rx_sample || rx_bit_end))
            check("rx strobe without tick", int'({rx_sample, rx_bit_end}), 0);
          if (rx_tick) begin
            if (rx_q.size() == 0) check("rx_tick unexpected, edge", cyc, -1);
            else begin
              ev = rx_q.pop_front();
              check("rx_tick edge", cyc, ev.cyc);
              check("rx phase/sample/bit_end",
                    int'(rx_phase) * 4 + (rx_sample ? 2 : 0) + (rx_bit_end ? 1 : 0), ev.flags);
            end
          end
        end
        if (tx_mon && tx_tick) begin
          if (tx_q.size() == 0) check("tx_tick unexpected, edge", cyc, -1);
          else begin
            t = tx_q.pop_front();
            check("tx_tick edge", cyc, t);
          end
        end
      end
    end
  end

  initial begin
    int r, e, er, d, n;
    rst_n = 1'b1; baud_we = 1'b0; baud_wsel = 1'b0; baud_wdata = 8'h00;
    rx_en = 1'b1; rx_restart = 1'b0; tx_en = 1'b1;
    #2 rst_n = 1'b0;

    // Reset defaults.
    repeat (3) @(negedge clk);
    check("reset div_q", int'(div_q), 325);
    check("reset rx_phase", int'(rx_phase), 0);
    check("reset strobes", int'({rx_tick, rx_sample, rx_bit_end, tx_tick}), 0);
    rst_n = 1'b1;
    r = cyc;
    rx_mon = 1'b1; tx_mon = 1'b1;
    push_rx(r + 1 + 326, 326, 32, 0);
    push_tx(r + 1 + 5216, 5216, 2);
    end_window(r + 1 + 10432);

    // Program 163; commit mid-bit at phase 3.
    wait_until(r + 1 + 326 * 35 + 5);
    check("rx_phase before commit", int'(rx_phase), 3);
    wr_lo(8'hA3);
    commit(8'h00, 1'b0, 1'b1, e);
    check("div_q after A3/00", int'(div_q), 163);
    check("rx_phase after commit", int'(rx_phase), 0);
    push_rx(e + 164, 164, 32, 0);
    push_tx(e + 2624, 2624, 2);
    end_window(e + 5248);

    // Clamp to MIN_DIV, then high-only write reuses the shadow.
    wr_lo(8'h00);
    commit(8'h00, 1'b0, 1'b1, e);
    check("div_q clamped", int'(div_q), 1);
    push_rx(e + 2, 2, 32, 0);
    push_tx(e + 32, 32, 2);
    end_window(e + 64);
    commit(8'h02, 1'b0, 1'b1, e);
    check("div_q shadow reuse", int'(div_q), 512);
    push_rx(e + 513, 513, 16, 0);
    push_tx(e + 8208, 8208, 1);
    end_window(e + 8208);

    // Resync at phase 5, mid-count.
    wr_lo(8'h09);
    commit(8'h00, 1'b0, 1'b1, e);
    check("div_q = 9", int'(div_q), 9);
    push_rx(e + 10, 10, 5, 0);
    push_tx(e + 160, 160, 1);
    wait_until(e + 56);
    check("rx_phase before restart", int'(rx_phase), 5);
    rx_restart = 1'b1;
    er = cyc + 1;
    @(negedge clk);
    rx_restart = 1'b0;
    check("rx_phase after restart", int'(rx_phase), 0);
    push_rx(er + 10, 10, 16, 0);
    end_window(er + 160);

    // Restart on the edge where a tick is due: that tick is suppressed.
    wait_until(er + 169);
    rx_restart = 1'b1;
    rx_mon = 1'b1;
    er = cyc + 1;
    @(negedge clk);
    rx_restart = 1'b0;
    push_rx(er + 10, 10, 2, 0);
    end_window(er + 20);

    // Commit and restart together.
    wr_lo(8'h45);
    commit(8'h01, 1'b1, 1'b1, e);
    check("div_q after 45/01", int'(div_q), 325);
    check("rx_phase after commit+restart", int'(rx_phase), 0);
    push_rx(e + 326, 326, 16, 0);
    push_tx(e + 5216, 5216, 1);
    end_window(e + 5216);

    // RX gating.
    wait_until(e + 326 * 18 + 5);
    check("rx_phase before rx_en low", int'(rx_phase), 2);
    @(negedge clk);
    rx_en = 1'b0;
    rx_mon = 1'b1;
    repeat (400) @(negedge clk);
    check("rx_phase while disabled", int'(rx_phase), 0);
    rx_en = 1'b1;
    d = cyc;
    push_rx(d + 1 + 326, 326, 1, 0);
    end_window(d + 1 + 326);

    // TX gating.
    @(negedge clk);
    tx_en = 1'b0;
    tx_mon = 1'b1;
    repeat (10000) @(negedge clk);
    tx_en = 1'b1;
    d = cyc;
    push_tx(d + 1 + 5216, 5216, 2);
    end_window(d + 1 + 10432);

    // Asynchronous reset between edges while an rx_tick is high.
    wr_lo(8'h09);
    commit(8'h00, 1'b0, 1'b0, e);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rx_tick && n < 100);
    check("rx_tick seen before async reset", int'(rx_tick), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset div_q", int'(div_q), 325);
    check("async reset rx_phase", int'(rx_phase), 0);
    check("async reset strobes", int'({rx_tick, rx_sample, rx_bit_end, tx_tick}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    rx_mon = 1'b1;
    push_rx(r + 1 + 326, 326, 1, 0);
    end_window(r + 1 + 326);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
